// File: rtl/chr_sram_reader.sv
// -----------------------------------------------------------------------------
// chr_sram_reader
//
// Purpose:
//   Serves PPU pattern-table byte fetches out of the 16-bit CHR SRAM once the
//   CHR boot loader has finished. A byte address {bank, ppu_addr} maps onto the
//   SRAM word {A[19:4], A[2:0]}; A[3] picks the high (1) or low (0) byte, so
//   both bitplanes of one tile row live in the same SRAM word.
//
// Optional feature (macro CHR_ROW_CACHE_EN):
//   Keeps the last fetched word plus its tag. A strobe hitting that word is
//   answered from the latch one cycle later without touching the SRAM.
//   The default build (macro undefined) always goes to the SRAM and carries no
//   tag logic.
//
// Ports:
//   i_clk, i_rst        PPU clock, asynchronous active-high reset
//   i_loader_done       loader finished (level, stays high after reset)
//   i_req               one-cycle read strobe
//   i_ppu_addr, i_bank  byte address and bank, sampled with i_req
//   o_ack, o_rdata      one-cycle ack; o_rdata valid with it and held after
//   o_busy              high while disabled or while an access is in flight
//   o_sram_*            SRAM address, read data and active-low controls
// -----------------------------------------------------------------------------
module chr_sram_reader #(
    parameter int WAIT_CYCLES = 1,   // 1..7 cycles between address and sample
    parameter int BANK_W      = 7    // BANK_W + 13 must equal 20
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_loader_done,
    input  logic              i_req,
    input  logic [12:0]       i_ppu_addr,
    input  logic [BANK_W-1:0] i_bank,
    output logic              o_ack,
    output logic [7:0]        o_rdata,
    output logic              o_busy,
    output logic [19:0]       o_sram_addr,
    input  logic [15:0]       i_sram_rdata,
    output logic              o_sram_oe_n,
    output logic              o_sram_we_n,
    output logic              o_sram_ub_n,
    output logic              o_sram_lb_n
);

    localparam logic [1:0] ST_DISABLED = 2'd0;
    localparam logic [1:0] ST_IDLE     = 2'd1;
    localparam logic [1:0] ST_ACCESS   = 2'd2;

    localparam logic [2:0] WAIT_LAST = 3'(WAIT_CYCLES);

    logic [1:0]  state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [19:0] addr_q, addr_d;
    logic        sel_hi_q, sel_hi_d;
    logic        oe_n_q, oe_n_d;
    logic        ack_q, ack_d;
    logic [7:0]  rdata_q, rdata_d;

    // Word address for the request currently on the inputs; the top bit is
    // always zero because the CHR image never exceeds 1 MiB.
    logic [19:0] req_addr;
    assign req_addr = {1'b0, i_bank, i_ppu_addr[12:4], i_ppu_addr[2:0]};

    logic [7:0] sram_byte;
    assign sram_byte = sel_hi_q ? i_sram_rdata[15:8] : i_sram_rdata[7:0];

`ifdef CHR_ROW_CACHE_EN
    localparam int TAG_W = BANK_W + 12;

    logic [15:0]       word_q, word_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic              valid_q, valid_d;
    logic [BANK_W-1:0] bank_prev_q, bank_prev_d;
    logic              cache_hit;
    logic [7:0]        cache_byte;

    // A bank change on the very edge of the strobe must not hit, so the
    // registered bank is compared in addition to the tag.
    assign cache_hit  = valid_q && (bank_prev_q == i_bank) &&
                        (tag_q == req_addr[TAG_W-1:0]);
    assign cache_byte = i_ppu_addr[3] ? word_q[15:8] : word_q[7:0];
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        sel_hi_d = sel_hi_q;
        oe_n_d   = oe_n_q;
        ack_d    = 1'b0;
        rdata_d  = rdata_q;
`ifdef CHR_ROW_CACHE_EN
        word_d      = word_q;
        tag_d       = tag_q;
        valid_d     = valid_q;
        bank_prev_d = i_bank;
`endif

        case (state_q)
            ST_DISABLED: begin
                if (i_loader_done) begin
                    state_d = ST_IDLE;
                end
            end

            ST_IDLE: begin
                if (i_req) begin
`ifdef CHR_ROW_CACHE_EN
                    if (cache_hit) begin
                        ack_d   = 1'b1;
                        rdata_d = cache_byte;
                    end else begin
                        addr_d   = req_addr;
                        sel_hi_d = i_ppu_addr[3];
                        oe_n_d   = 1'b0;
                        cnt_d    = 3'd0;
                        state_d  = ST_ACCESS;
                    end
`else
                    addr_d   = req_addr;
                    sel_hi_d = i_ppu_addr[3];
                    oe_n_d   = 1'b0;
                    cnt_d    = 3'd0;
                    state_d  = ST_ACCESS;
`endif
                end
            end

            ST_ACCESS: begin
                if (cnt_q == WAIT_LAST) begin
                    rdata_d = sram_byte;
                    ack_d   = 1'b1;
                    oe_n_d  = 1'b1;
                    state_d = ST_IDLE;
`ifdef CHR_ROW_CACHE_EN
                    word_d  = i_sram_rdata;
                    tag_d   = addr_q[TAG_W-1:0];
                    valid_d = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end

            default: begin
                state_d = ST_DISABLED;
                oe_n_d  = 1'b1;
            end
        endcase

`ifdef CHR_ROW_CACHE_EN
        // The cached word belongs to a specific bank; any bank switch drops it.
        if (i_bank != bank_prev_q) begin
            valid_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= ST_DISABLED;
            cnt_q    <= 3'd0;
            addr_q   <= 20'd0;
            sel_hi_q <= 1'b0;
            oe_n_q   <= 1'b1;
            ack_q    <= 1'b0;
            rdata_q  <= 8'h00;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            sel_hi_q <= sel_hi_d;
            oe_n_q   <= oe_n_d;
            ack_q    <= ack_d;
            rdata_q  <= rdata_d;
        end
    end

`ifdef CHR_ROW_CACHE_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            word_q      <= 16'h0000;
            tag_q       <= '0;
            valid_q     <= 1'b0;
            bank_prev_q <= '0;
        end else begin
            word_q      <= word_d;
            tag_q       <= tag_d;
            valid_q     <= valid_d;
            bank_prev_q <= bank_prev_d;
        end
    end
`endif

    assign o_ack       = ack_q;
    assign o_rdata     = rdata_q;
    assign o_busy      = (state_q != ST_IDLE);
    assign o_sram_addr = addr_q;
    // Byte lanes always follow OE: both bytes of the word are read every time.
    assign o_sram_oe_n = oe_n_q;
    assign o_sram_ub_n = oe_n_q;
    assign o_sram_lb_n = oe_n_q;
    assign o_sram_we_n = 1'b1;

endmodule

// File: tb/tb_chr_sram_reader.sv
// -----------------------------------------------------------------------------
// tb_chr_sram_reader
//
// Two instances share all inputs: WAIT_CYCLES=1 (index 0) and WAIT_CYCLES=3
// (index 1). Each sees its own SRAM model. Expected bytes, latencies and cache
// behaviour come from a byte-address level model kept in this bench.
// -----------------------------------------------------------------------------
module tb_chr_sram_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        done;
    logic        req;
    logic [12:0] ppu_addr;
    logic [6:0]  bank;

    logic        ack   [2];
    logic        busy  [2];
    logic        oe_n  [2];
    logic        we_n  [2];
    logic        ub_n  [2];
    logic        lb_n  [2];
    logic [7:0]  rdata [2];
    logic [19:0] saddr [2];
    logic [15:0] srdata[2];

    int checks   = 0;
    int failures = 0;
    int waits[2] = '{1, 3};

    // Reference model state: single-entry row cache as seen from outside.
    bit          cv;
    logic [19:0] ctag;
    logic [6:0]  last_bank;

    always #5 clk = ~clk;

    function automatic logic [15:0] sram_word(input logic [19:0] a);
        logic [7:0] hi;
        logic [7:0] lo;
        case (a)
            20'h0200D: return 16'hA55A;
            20'h0300D: return 16'h5AC3;
            default: begin
                hi = a[7:0] + a[19:12] + 8'h51;
                lo = a[7:0] ^ a[15:8] ^ 8'h96;
                return {hi, lo};
            end
        endcase
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        chr_sram_reader #(
            .WAIT_CYCLES((gi == 0) ? 1 : 3),
            .BANK_W     (7)
        ) u_dut (
            .i_clk        (clk),
            .i_rst        (rst),
            .i_loader_done(done),
            .i_req        (req),
            .i_ppu_addr   (ppu_addr),
            .i_bank       (bank),
            .o_ack        (ack[gi]),
            .o_rdata      (rdata[gi]),
            .o_busy       (busy[gi]),
            .o_sram_addr  (saddr[gi]),
            .i_sram_rdata (srdata[gi]),
            .o_sram_oe_n  (oe_n[gi]),
            .o_sram_we_n  (we_n[gi]),
            .o_sram_ub_n  (ub_n[gi]),
            .o_sram_lb_n  (lb_n[gi])
        );
        // Garbage while OE is off exposes sampling outside the access window.
        assign srdata[gi] = oe_n[gi] ? 16'hDEAD : sram_word(saddr[gi]);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // mode 0: plain strobe; 1: second strobe while busy; 2: reset mid-access
    task automatic do_req(input logic [6:0] b, input logic [12:0] a, input int mode);
        logic [19:0] byte_a;
        logic [19:0] w;
        logic [15:0] wd;
        logic [7:0]  eb;
        bit          hit;
        int          ack_n[2];
        int          ack_c[2];
        int          oe_c[2];
        int          ub_c[2];
        int          lb_c[2];
        logic [7:0]  rd[2];
        bit          addr_bad[2];
        logic        busy1[2];
        int          exp_ack_c;
        int          exp_oe;

        byte_a = {b, a};
        w      = {1'b0, byte_a[19:4], byte_a[2:0]};
        wd     = sram_word(w);
        eb     = byte_a[3] ? wd[15:8] : wd[7:0];
        if (b != last_bank) cv = 0;
        last_bank = b;
`ifdef CHR_ROW_CACHE_EN
        hit = cv && (ctag == w);
`else
        hit = 0;
`endif
        if (hit && mode == 1) mode = 0;
        for (int i = 0; i < 2; i++) begin
            ack_n[i] = 0; ack_c[i] = 0; oe_c[i] = 0; ub_c[i] = 0; lb_c[i] = 0;
            rd[i] = 8'h00; addr_bad[i] = 0; busy1[i] = 1'b0;
        end

        @(negedge clk);
        bank = b; ppu_addr = a; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        ppu_addr = 13'($urandom);   // must not disturb the access in flight
        for (int c = 1; c <= 12; c++) begin
            if (c == 1 && mode == 1) begin
                req = 1'b1;
                ppu_addr = 13'($urandom);
            end
            if (c == 1 && mode == 2) begin
                rst = 1'b1;
                #1;
                for (int i = 0; i < 2; i++) begin
                    check($sformatf("rst_oe_n%0d", i), 32'(oe_n[i]), 32'd1);
                    check($sformatf("rst_rdata%0d", i), 32'(rdata[i]), 32'h0);
                end
            end
            if (c == 2) begin
                req = 1'b0;
                rst = 1'b0;
            end
            for (int i = 0; i < 2; i++) begin
                if (ack[i]) begin
                    ack_n[i]++;
                    ack_c[i] = c;
                    rd[i] = rdata[i];
                end
                if (!oe_n[i]) begin
                    oe_c[i]++;
                    if (saddr[i] !== w) addr_bad[i] = 1;
                end
                if (!ub_n[i]) ub_c[i]++;
                if (!lb_n[i]) lb_c[i]++;
                if (c == 1) busy1[i] = busy[i];
            end
            @(negedge clk);
        end

        for (int i = 0; i < 2; i++) begin
            if (mode == 2) begin
                check($sformatf("rst_no_ack%0d", i), 32'(ack_n[i]), 32'd0);
                check($sformatf("rst_oe_cnt%0d", i), 32'(oe_c[i]), 32'd0);
            end else begin
                exp_ack_c = hit ? 1 : waits[i] + 2;
                exp_oe    = hit ? 0 : waits[i] + 1;
                check($sformatf("ack_count%0d", i), 32'(ack_n[i]), 32'd1);
                check($sformatf("ack_cycle%0d", i), 32'(ack_c[i]), 32'(exp_ack_c));
                check($sformatf("ack_rdata%0d", i), 32'(rd[i]), 32'(eb));
                check($sformatf("held_rdata%0d", i), 32'(rdata[i]), 32'(eb));
                check($sformatf("oe_cycles%0d", i), 32'(oe_c[i]), 32'(exp_oe));
                check($sformatf("ub_cycles%0d", i), 32'(ub_c[i]), 32'(exp_oe));
                check($sformatf("lb_cycles%0d", i), 32'(lb_c[i]), 32'(exp_oe));
                check($sformatf("sram_addr%0d", i), 32'(addr_bad[i]), 32'd0);
                check($sformatf("busy_c1_%0d", i), 32'(busy1[i]), 32'(!hit));
            end
        end
        $display("txn bank=%0d addr=%h word=%h hit=%0d mode=%0d exp=%h got=%h/%h ack_cycle=%0d/%0d",
                 b, a, w, hit, mode, eb, rd[0], rd[1], ack_c[0], ack_c[1]);

        if (mode == 2) begin
            cv = 0;
        end else if (!hit) begin
            cv   = 1;
            ctag = w;
        end
    endtask

    initial begin
        logic [12:0] a;
        logic [6:0]  b;
        int          mode;
        int          bad_ack[2];
        int          bad_ctl[2];

        rst = 1'b1; done = 1'b0; req = 1'b0; bank = 7'd0; ppu_addr = 13'd0;
        cv = 0; ctag = 20'd0; last_bank = 7'd0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("reset_ack%0d", i),   32'(ack[i]),   32'd0);
            check($sformatf("reset_rdata%0d", i), 32'(rdata[i]), 32'h00);
            check($sformatf("reset_busy%0d", i),  32'(busy[i]),  32'd1);
            check($sformatf("reset_addr%0d", i),  32'(saddr[i]), 32'h0);
            check($sformatf("reset_ctl%0d", i),
                  32'({oe_n[i], ub_n[i], lb_n[i], we_n[i]}), 32'hF);
        end
        rst = 1'b0;

        // Loader not done: strobes are ignored and the SRAM stays released.
        for (int i = 0; i < 2; i++) begin
            bad_ack[i] = 0;
            bad_ctl[i] = 0;
        end
        for (int k = 0; k < 6; k++) begin
            req = 1'b1;
            ppu_addr = 13'($urandom);
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (ack[i]) bad_ack[i]++;
                if (!busy[i] || !oe_n[i] || !ub_n[i] || !lb_n[i] || !we_n[i]) bad_ctl[i]++;
            end
        end
        req = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("disabled_ack%0d", i), 32'(bad_ack[i]), 32'd0);
            check($sformatf("disabled_ctl%0d", i), 32'(bad_ctl[i]), 32'd0);
        end

        done = 1'b1;
        repeat (2) @(negedge clk);

        do_req(7'd2, 13'h0015, 0);   // word 0x0200D, low byte 0x5A
        do_req(7'd2, 13'h001D, 0);   // same word, high byte 0xA5
        do_req(7'd2, 13'h0125, 1);   // extra strobe while busy is dropped
        do_req(7'd3, 13'h001D, 0);   // new bank -> word 0x0300D
        do_req(7'd3, 13'h00A7, 2);   // reset during the access
        do_req(7'd3, 13'h001D, 0);   // served normally after reset

        a = 13'h001D;
        b = 7'd3;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 4) == 0) b = 7'($urandom_range(0, 127));
            if ($urandom_range(0, 1) == 0) a = a ^ 13'h0008;
            else                            a = 13'($urandom);
            case ($urandom_range(0, 9))
                0:       mode = 1;
                1:       mode = 2;
                default: mode = 0;
            endcase
            do_req(b, a, mode);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
